// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master
//  Purpose  : APB requester. Turns a valid/ready command stream
//             (address, write flag, write data) into APB SETUP/ACCESS
//             transfers, waits for PREADY, and returns a valid/ready
//             response carrying read data and an error flag.
//             One transfer is in flight at a time.
//  Ports    : PCLK, PRESETn (async, active-low)
//             cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata - command in
//             rsp_valid/rsp_ready/rsp_rdata/rsp_err            - response out
//             PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY   - APB bus
//  Options  : APB_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that
//             waits TIMEOUT_CYC cycles without PREADY is aborted with
//             rsp_err=1. When undefined, rsp_err is tied 0 and ACCESS
//             waits indefinitely.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    // command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB requester side
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;

    // A zero limit would abort before the slave ever sees ACCESS.
    generate
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("apb_master: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int              c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    // Counter holds the number of PREADY=0 cycles already spent in ACCESS,
    // so the cycle that would make it TIMEOUT_CYC is the abort cycle.
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYC - 1);

    logic                r_rsp_err;
    logic [c_CNT_W-1:0]  r_wait_cnt;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
            r_wait_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // cmd_ready is high throughout IDLE, so cmd_valid alone
                    // completes the handshake here.
                    if (cmd_valid) begin
                        r_pwrite <= cmd_write;
                        r_paddr  <= cmd_addr;
                        r_pwdata <= cmd_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= ST_SETUP;
                    end else begin
                        r_psel   <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_state    <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        // Write responses carry zero data; read data is
                        // passed through untouched.
                        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= ST_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
                    end else if (r_wait_cnt == c_LIMIT) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + c_CNT_W'(1);
`endif
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master
//  Purpose  : Directed self-checking bench for apb_master. Inputs are driven
//             and outputs sampled 1 time unit after each rising PCLK edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic              PCLK;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    int n_cmp = 0;
    int n_err = 0;

    apb_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // Present a command and hold it until the edge that accepts it
    // (DUT is expected to be in IDLE); returns in the SETUP cycle.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        tick;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;

        // ---------------- reset state ----------------
        tick;
        tick;
        check("rst_psel",    PSEL,      1'b0);
        check("rst_penable", PENABLE,   1'b0);
        check("rst_pwrite",  PWRITE,    1'b0);
        check("rst_paddr",   PADDR,     32'h0);
        check("rst_pwdata",  PWDATA,    32'h0);
        check("rst_rvalid",  rsp_valid, 1'b0);
        check("rst_rdata",   rsp_rdata, 32'h0);
        check("rst_err",     rsp_err,   1'b0);
        PRESETn = 1'b1;
        tick;
        check("rst_cmd_ready", cmd_ready, 1'b1);

        // ---------------- 1: write, no wait states ----------------
        rsp_ready = 1'b1;
        PREADY    = 1'b1;       // high during SETUP too; must be ignored there
        issue(1'b1, 32'h10, 32'hDEADBEEF);
        check("t1_c1_psel",    PSEL,      1'b1);
        check("t1_c1_penable", PENABLE,   1'b0);
        check("t1_c1_pwrite",  PWRITE,    1'b1);
        check("t1_c1_paddr",   PADDR,     32'h10);
        check("t1_c1_pwdata",  PWDATA,    32'hDEADBEEF);
        check("t1_c1_cready",  cmd_ready, 1'b0);
        tick;
        check("t1_c2_psel",    PSEL,      1'b1);
        check("t1_c2_penable", PENABLE,   1'b1);
        check("t1_c2_pwdata",  PWDATA,    32'hDEADBEEF);
        check("t1_c2_rvalid",  rsp_valid, 1'b0);
        PRDATA = 32'h5555AAAA;  // must not appear in a write response
        tick;
        check("t1_c3_rvalid",  rsp_valid, 1'b1);
        check("t1_c3_rdata",   rsp_rdata, 32'h0);
        check("t1_c3_err",     rsp_err,   1'b0);
        check("t1_c3_psel",    PSEL,      1'b0);
        check("t1_c3_penable", PENABLE,   1'b0);
        check("t1_c3_pwdata",  PWDATA,    32'hDEADBEEF);
        tick;
        check("t1_c4_rvalid",  rsp_valid, 1'b0);
        check("t1_c4_cready",  cmd_ready, 1'b1);

        // ---------------- 2+3: read with 3 wait states, slow consumer ----------------
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PRDATA    = 32'h12345678;
        issue(1'b0, 32'h10, 32'h0);
        check("t2_setup_pwrite", PWRITE, 1'b0);
        tick;                   // first ACCESS cycle
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (PENABLE === 1'b1) n++;
            check("t2_paddr_stable", PADDR, 32'h10);
            if (i == 3) begin
                PREADY = 1'b1;
                PRDATA = 32'hDEADBEEF;
            end
            tick;
        end
        PREADY = 1'b0;
        PRDATA = 32'h0BADF00D;
        check("t2_penable_cycles", n, 4);
        check("t2_rvalid",   rsp_valid, 1'b1);
        check("t2_rdata",    rsp_rdata, 32'hDEADBEEF);
        check("t2_penable",  PENABLE,   1'b0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t3_hold_rvalid", rsp_valid, 1'b1);
            check("t3_hold_rdata",  rsp_rdata, 32'hDEADBEEF);
            check("t3_hold_cready", cmd_ready, 1'b0);
            check("t3_hold_psel",   PSEL,      1'b0);
        end
        rsp_ready = 1'b1;
        tick;
        check("t3_rel_rvalid", rsp_valid, 1'b0);
        check("t3_rel_cready", cmd_ready, 1'b1);

        // ---------------- 4: two queued commands ----------------
        PREADY    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h20;
        cmd_wdata = 32'h11111111;
        tick;                   // A accepted -> SETUP
        check("t4_a_psel",  PSEL,  1'b1);
        check("t4_a_paddr", PADDR, 32'h20);
        cmd_write = 1'b0;       // B presented immediately, held continuously
        cmd_addr  = 32'h24;
        cmd_wdata = 32'h22222222;
        tick;                   // ACCESS
        check("t4_a_penable", PENABLE, 1'b1);
        check("t4_a_paddr2",  PADDR,   32'h20);
        PRDATA = 32'hCAFEF00D;
        tick;                   // RESP for A
        check("t4_a_rvalid", rsp_valid, 1'b1);
        check("t4_a_cready", cmd_ready, 1'b0);
        check("t4_a_hold",   PADDR,     32'h20);
        tick;                   // IDLE, B accepted at the coming edge
        check("t4_gap_psel",   PSEL,      1'b0);
        check("t4_gap_cready", cmd_ready, 1'b1);
        tick;                   // B SETUP
        cmd_valid = 1'b0;
        check("t4_b_psel",   PSEL,   1'b1);
        check("t4_b_paddr",  PADDR,  32'h24);
        check("t4_b_pwrite", PWRITE, 1'b0);
        tick;
        tick;
        check("t4_b_rvalid", rsp_valid, 1'b1);
        check("t4_b_rdata",  rsp_rdata, 32'hCAFEF00D);
        tick;
        check("t4_b_idle", cmd_ready, 1'b1);

        // ---------------- 5: reset mid-ACCESS ----------------
        PREADY = 1'b0;
        issue(1'b0, 32'h30, 32'h0);
        tick;
        check("t5_in_access", PENABLE, 1'b1);
        #2 PRESETn = 1'b0;
        #1;
        check("t5_async_psel",    PSEL,      1'b0);
        check("t5_async_penable", PENABLE,   1'b0);
        check("t5_async_rvalid",  rsp_valid, 1'b0);
        check("t5_async_paddr",   PADDR,     32'h0);
        #2 PRESETn = 1'b1;
        PREADY = 1'b1;
        #1;
        check("t5_rel_cready", cmd_ready, 1'b1);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rsp_valid !== 1'b0 || PSEL !== 1'b0) n++;
        end
        check("t5_no_response", n, 0);

        // ---------------- 6: PREADY stuck low ----------------
        PREADY = 1'b0;
        issue(1'b0, 32'h40, 32'h0);
        tick;                   // first ACCESS cycle
`ifdef APB_MASTER_TIMEOUT_EN
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            if (PENABLE === 1'b1) n++;
            tick;
        end
        check("t6_abort_cycles", n, 16);
        check("t6_abort_rvalid", rsp_valid, 1'b1);
        check("t6_abort_err",    rsp_err,   1'b1);
        check("t6_abort_rdata",  rsp_rdata, 32'h0);
        check("t6_abort_psel",   PSEL,      1'b0);
        tick;
        // PREADY arriving on the limit cycle completes normally
        issue(1'b0, 32'h44, 32'h0);
        tick;                   // ACCESS cycle 1
        repeat (15) tick;       // now in ACCESS cycle 16
        PREADY = 1'b1;
        PRDATA = 32'hA5A5A5A5;
        tick;
        check("t6_tie_rvalid", rsp_valid, 1'b1);
        check("t6_tie_err",    rsp_err,   1'b0);
        check("t6_tie_rdata",  rsp_rdata, 32'hA5A5A5A5);
        tick;
`else
        repeat (100) tick;
        check("t6_wait_psel",    PSEL,      1'b1);
        check("t6_wait_penable", PENABLE,   1'b1);
        check("t6_wait_rvalid",  rsp_valid, 1'b0);
        check("t6_wait_err",     rsp_err,   1'b0);
        PREADY = 1'b1;
        PRDATA = 32'h600DCAFE;
        tick;
        check("t6_done_rvalid", rsp_valid, 1'b1);
        check("t6_done_rdata",  rsp_rdata, 32'h600DCAFE);
        check("t6_done_err",    rsp_err,   1'b0);
        tick;
`endif
        check("t6_end_idle", cmd_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester stage that sits directly upstream of the team's APB slave memory.
- Converts a simple valid/ready command stream (address, write flag, write data) into compliant APB SETUP/ACCESS transfers.
- Waits for PREADY, then returns a valid/ready response carrying read data and an error flag.
- One transfer is in flight at a time. This block is the sole driver of PSEL, PENABLE, PWRITE, PADDR and PWDATA.

Parameters:
- ADDR_W, 32, width of PADDR and cmd_addr.
- DATA_W, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYC, 16, ACCESS-phase wait limit in cycles (used only with the optional feature); must be at least 1.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Interface decision: one clock, PCLK. Reset PRESETn is asynchronous and active-low.
- Reset values: state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. cmd_ready=1 immediately after reset is released.
- Outputs are registered, except cmd_ready, which is combinational: (state==IDLE).
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE: on cmd_valid&&cmd_ready:
  - latch cmd_write into PWRITE, cmd_addr into PADDR, cmd_wdata into PWDATA;
  - set PSEL=1; go to SETUP.
  - Otherwise remain in IDLE with PSEL=0.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0; set PENABLE=1; go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PREADY is sampled every cycle.
  - PREADY=0: remain in ACCESS.
  - PREADY=1: capture PRDATA into rsp_rdata for reads, or load 0 for writes; rsp_err=0; rsp_valid=1; PSEL=0; PENABLE=0; go to RESP.
- RESP: hold rsp_valid, rsp_rdata and rsp_err until rsp_ready=1, then clear rsp_valid and go to IDLE.
- Latency, command accepted at edge 0: SETUP visible cycle 1, ACCESS cycle 2. With PREADY=1 in cycle 2, rsp_valid=1 in cycle 3.
- Minimum 4 cycles per transfer. No back-to-back APB transfers: PSEL is low for at least one cycle between transfers.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the final ACCESS cycle. They keep their last values after the transfer until the next accept.
- cmd_valid while busy is ignored (cmd_ready=0). The upstream holds the command until it is accepted.
- rsp_ready while rsp_valid=0 has no effect.
- PREADY outside ACCESS is ignored. PRDATA is captured as-is, including X, and never inspected.
- PRESETn asserted in any state: all outputs return to reset values asynchronously. The in-flight command is dropped and no response is ever produced for it.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle in which PREADY=0.
  - When the counter reaches TIMEOUT_CYC with PREADY still 0: abort the transfer with PSEL=0, PENABLE=0, rsp_rdata=0, rsp_err=1, rsp_valid=1, and go to RESP.
  - PREADY=1 in the same cycle the limit is reached wins: normal completion with rsp_err=0.
- Undefined: the counter logic is absent, rsp_err is tied 0, and ACCESS waits indefinitely.

Test Plan:
1. Write addr 0x10, data 0xDEADBEEF, PREADY=1 in the first ACCESS cycle -> PSEL=1 cycle 1, PENABLE=1 cycle 2, rsp_valid=1 cycle 3, rsp_rdata=0, rsp_err=0, PWDATA=0xDEADBEEF throughout.
2. Read addr 0x10 with 3 wait states, PRDATA=0xDEADBEEF -> PENABLE high for 4 cycles, PADDR stable at 0x10, rsp_rdata=0xDEADBEEF.
3. rsp_ready held low for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata held, cmd_ready=0, PSEL=0; IDLE in the cycle after rsp_ready=1.
4. cmd_valid held continuously with 2 queued commands -> second accepted only after the first response handshake; PSEL=0 for at least 1 cycle between the two transfers.
5. PRESETn pulsed low mid-ACCESS -> PSEL, PENABLE and rsp_valid fall to 0 without a clock edge; cmd_ready=1 after release; no response for the dropped command.
6. With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYC=16, PREADY stuck 0 -> abort after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0. Without the macro, still in ACCESS after 100 cycles.
